// File: rtl/paula_audio_mix_sched.sv
// paula_audio_mix_sched
//   One shared 8x6 signed-by-unsigned volume multiplier is time-multiplexed
//   across the four Paula audio channels. A start strobe snapshots all four
//   samples, volumes and enables. The block then presents one channel per
//   cycle to the multiplier and sums the 14-bit products into 15-bit left and
//   right mixes. The finished mix is published with a one-cycle valid pulse.
//
// Ports
//   clk, reset    system clock, asynchronous active-high reset
//   start         one-cycle strobe that begins a mix pass
//   sample[31:0]  ch n signed sample at [8n+7:8n]
//   volume[27:0]  ch n unsigned volume 0..64 at [7n+6:7n]
//   chan_en[3:0]  per-channel enable (0 = contributes zero)
//   mul_sample    signed operand to the shared multiplier (0 when not in CHn)
//   mul_volume    unsigned operand to the shared multiplier (0 when not in CHn)
//   mul_product   signed product, combinational from mul_sample/mul_volume
//   left, right   signed 15-bit mixes, updated only when valid is high
//   valid         one-cycle pulse in DONE: left/right carry the new mix
//   busy          a pass is in progress (state != IDLE)
//   overrun       one-cycle pulse: start seen while busy (start is dropped)
//
// Handshake: start has no ready. It is accepted only in IDLE. A start in any
// other state, including DONE, is ignored and flagged on overrun in that same
// cycle. valid is a pulse and has no back-pressure.
module paula_audio_mix_sched #(
  parameter logic [3:0] LEFT_MASK = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] sample,
  input  logic [27:0] volume,
  input  logic [3:0]  chan_en,
  output logic [7:0]  mul_sample,
  output logic [5:0]  mul_volume,
  input  logic [13:0] mul_product,
  output logic [14:0] left,
  output logic [14:0] right,
  output logic        valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    CH3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [31:0] sample_q;
  logic [27:0] volume_q;
  logic [3:0]  en_q;
  logic [14:0] accl_q, accr_q;
  logic [14:0] accl_d, accr_d;

  logic        is_ch;
  logic [1:0]  idx;
  logic [7:0]  sel_sample;
  logic [6:0]  sel_volume;
  logic        sel_en;
  logic [13:0] contrib;
  logic [14:0] contrib_ext;

  // Decode the current channel slot from the state.
  always_comb begin
    is_ch = 1'b0;
    idx   = 2'd0;
    case (state_q)
      CH0:     begin is_ch = 1'b1; idx = 2'd0; end
      CH1:     begin is_ch = 1'b1; idx = 2'd1; end
      CH2:     begin is_ch = 1'b1; idx = 2'd2; end
      CH3:     begin is_ch = 1'b1; idx = 2'd3; end
      default: begin is_ch = 1'b0; idx = 2'd0; end
    endcase
  end

  // Select the snapshot fields of the active channel.
  always_comb begin
    sel_sample = 8'd0;
    sel_volume = 7'd0;
    sel_en     = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (idx == n[1:0]) begin
        sel_sample = sample_q[8*n +: 8];
        sel_volume = volume_q[7*n +: 7];
        sel_en     = en_q[n];
      end
    end
  end

  // Multiplier operands and this channel's contribution. Volume bit 6 means
  // full scale (x64). That case is an exact shift, because the 6-bit
  // multiplier operand cannot represent 64. The low volume bits are still
  // driven on mul_volume, but the product is not used.
  always_comb begin
    mul_sample = 8'd0;
    mul_volume = 6'd0;
    contrib    = 14'd0;
    if (is_ch) begin
      mul_sample = sel_sample;
      mul_volume = sel_volume[5:0];
      if (!sel_en)
        contrib = 14'd0;
      else if (sel_volume[6])
        contrib = {sel_sample, 6'b000000};
      else
        contrib = mul_product;
    end
  end

  assign contrib_ext = {contrib[13], contrib};

  // At most two 14-bit terms land on each side, so 15 bits never overflow.
  always_comb begin
    accl_d = accl_q;
    accr_d = accr_q;
    if (is_ch) begin
      if (LEFT_MASK[idx])
        accl_d = accl_q + contrib_ext;
      else
        accr_d = accr_q + contrib_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CH0;
      CH0:     state_d = CH1;
      CH1:     state_d = CH2;
      CH2:     state_d = CH3;
      CH3:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      volume_q <= '0;
      en_q     <= '0;
      accl_q   <= '0;
      accr_q   <= '0;
      left     <= '0;
      right    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sample_q <= sample;
        volume_q <= volume;
        en_q     <= chan_en;
        accl_q   <= '0;
        accr_q   <= '0;
      end else if (is_ch) begin
        accl_q <= accl_d;
        accr_q <= accr_d;
      end
      // Load the mix on the CH3 -> DONE edge so that it is visible during
      // the DONE cycle, together with valid.
      if (state_q == CH3) begin
        left  <= accl_d;
        right <= accr_d;
      end
    end
  end

  assign valid   = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign overrun = start && busy;

endmodule

// File: tb/tb_paula_audio_mix_sched.sv
module tb_paula_audio_mix_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] sample;
  logic [27:0] volume;
  logic [3:0]  chan_en;
  logic [7:0]  mul_sample;
  logic [5:0]  mul_volume;
  logic [13:0] mul_product;
  logic [14:0] left;
  logic [14:0] right;
  logic        valid;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;

  paula_audio_mix_sched dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sample      (sample),
    .volume      (volume),
    .chan_en     (chan_en),
    .mul_sample  (mul_sample),
    .mul_volume  (mul_volume),
    .mul_product (mul_product),
    .left        (left),
    .right       (right),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Shared multiplier model: signed sample times unsigned volume, 14 bits.
  assign mul_product = {{6{mul_sample[7]}}, mul_sample} * {8'd0, mul_volume};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [27:0] v;
    logic [3:0]  en;
    int          el;
    int          er;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] ps(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [27:0] pv(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs are driven on the falling edge. Checks run 1 time unit later,
  // which is well away from the rising edge.
  task automatic set_inputs(input vec_t t);
    sample  = t.s;
    volume  = t.v;
    chan_en = t.en;
  endtask

  // Run one full pass with vector t. Checks the timing of valid and busy
  // and the final mix.
  task automatic run_pass(input vec_t t, input string tag);
    @(negedge clk);
    set_inputs(t);
    start = 1'b1;
    #1;
    check({tag, " overrun@T"}, int'(overrun), 0);
    check({tag, " busy@T"}, int'(busy), 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check($sformatf("%s valid@T+%0d", tag, k), int'(valid), (k == 5) ? 1 : 0);
      check($sformatf("%s busy@T+%0d", tag, k), int'(busy), (k <= 5) ? 1 : 0);
      if (k == 5) begin
        check({tag, " left"},  int'($signed(left)),  t.el);
        check({tag, " right"}, int'($signed(right)), t.er);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    sample  = '0;
    volume  = '0;
    chan_en = '0;

    vecs[0] = '{ps(8'h64, 8'h00, 8'h00, 8'hEC), pv(7'd32, 7'd0, 7'd0, 7'd64), 4'hF, 1920, 0};
    vecs[1] = '{ps(8'h80, 8'h80, 8'h80, 8'h80), pv(7'd64, 7'd64, 7'd64, 7'd64), 4'hF, -16384, -16384};
    vecs[2] = '{ps(8'h7F, 8'h7F, 8'h7F, 8'h7F), pv(7'd64, 7'd64, 7'd64, 7'd64), 4'hF, 16256, 16256};
    vecs[3] = '{ps(8'h40, 8'h40, 8'h40, 8'h40), pv(7'd10, 7'd10, 7'd10, 7'd10), 4'b0110, 0, 1280};
    vecs[4] = '{ps(8'h01, 8'hCE, 8'h0A, 8'hFF), pv(7'd0, 7'd63, 7'd100, 7'd1), 4'hF, -1, -2510};
    vecs[5] = '{ps(8'hFF, 8'h05, 8'h05, 8'h05), pv(7'd127, 7'd64, 7'd0, 7'd0), 4'b0001, -64, 0};

    repeat (3) @(negedge clk);
    #1;
    check("reset valid", int'(valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset left", int'(left), 0);
    check("reset right", int'(right), 0);
    check("reset mul_sample", int'(mul_sample), 0);
    reset = 1'b0;

    // Table-driven passes.
    for (int i = 0; i < 6; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

    // The snapshot must ignore input changes made during the pass.
    @(negedge clk);
    set_inputs(vecs[0]);
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start   = 1'b0;
      sample  = $urandom();
      volume  = 28'($urandom());
      chan_en = 4'($urandom_range(0, 15));
      #1;
      if (k == 1) check("snap mul_sample ch0", int'(mul_sample), 100);
      if (k == 1) check("snap mul_volume ch0", int'(mul_volume), 32);
      if (k == 5) begin
        check("snap valid", int'(valid), 1);
        check("snap left", int'($signed(left)), 1920);
        check("snap right", int'($signed(right)), 0);
      end
    end
    @(negedge clk);
    #1;
    check("idle mul_sample", int'(mul_sample), 0);
    check("idle mul_volume", int'(mul_volume), 0);

    // Starts during the pass and in DONE are overruns, not new passes.
    @(negedge clk);
    set_inputs(vecs[3]);
    start = 1'b1;
    #1;
    check("ovr overrun@T", int'(overrun), 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 5);
      if (k == 3) set_inputs(vecs[1]);
      #1;
      check($sformatf("ovr overrun@T+%0d", k), int'(overrun), (k == 3 || k == 5) ? 1 : 0);
      check($sformatf("ovr valid@T+%0d", k), int'(valid), (k == 5) ? 1 : 0);
      if (k >= 6) check($sformatf("ovr busy@T+%0d", k), int'(busy), 0);
      if (k == 5) begin
        check("ovr left", int'($signed(left)), 0);
        check("ovr right", int'($signed(right)), 1280);
      end
    end

    // Reset during CH2 aborts the pass and clears the mixes.
    run_pass(vecs[2], "pre-reset");
    @(negedge clk);
    set_inputs(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst in CH2 busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst left", int'(left), 0);
    check("rst right", int'(right), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst no valid %0d", k), int'(valid), 0);
    end
    check("rst left hold", int'(left), 0);
    run_pass(vecs[0], "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
